m_dram_app_responder: RTL and testbench

- Cycle-level responder for the DDR3 MIG user (app) interface.
- Sits on the far side of m_cached_memory's app_* port and stands in for the MIG in simulation and small on-chip builds.
- Accepts read/write commands and write data, stores 128-bit lines in an internal array, and returns read data in order after a fixed latency.
- Lets the cache refill/writeback paths run without a DDR3 controller.

---
 rtl/m_dram_app_responder.sv | 189 ++++++++++++++++++
 tb/tb_m_dram_app_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/m_dram_app_responder.sv
// Behavioural stand-in for the DDR3 MIG user interface: 4-deep command and write-data FIFOs,
// an internal line array, and a fixed-latency in-order read pipeline. Optional macro: DRAM_RDY_THROTTLE_EN.
module m_dram_app_responder #(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_CMD_WIDTH  = 3,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16,
    parameter int MEM_LINES_LOG2 = 10,
    parameter int RD_LATENCY     = 8,
    parameter int CALIB_CYCLES   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_x,
    input  logic [APP_ADDR_WIDTH-1:0] i_app_addr,
    input  logic [APP_CMD_WIDTH-1:0]  i_app_cmd,
    input  logic                      i_app_en,
    output logic                      o_app_rdy,
    input  logic [APP_DATA_WIDTH-1:0] i_app_wdf_data,
    input  logic [APP_MASK_WIDTH-1:0] i_app_wdf_mask,
    input  logic                      i_app_wdf_wren,
    input  logic                      i_app_wdf_end,
    output logic                      o_app_wdf_rdy,
    output logic [APP_DATA_WIDTH-1:0] o_app_rd_data,
    output logic                      o_app_rd_data_valid,
    output logic                      o_app_rd_data_end,
    output logic                      o_init_calib_complete
);

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;
    localparam int CAL_W      = $clog2(CALIB_CYCLES + 1);
    localparam int MEM_LINES  = 1 << MEM_LINES_LOG2;

    localparam logic [APP_CMD_WIDTH-1:0] CMD_WRITE = APP_CMD_WIDTH'(0);
    localparam logic [APP_CMD_WIDTH-1:0] CMD_READ  = APP_CMD_WIDTH'(1);

    // ---------------- calibration ----------------
    logic [CAL_W-1:0] r_calib_cnt;
    logic             r_calib;

    always_ff @(posedge i_clk) begin
        if (!i_rst_x) begin
            r_calib_cnt <= '0;
            r_calib     <= 1'b0;
        end else if (!r_calib) begin
            r_calib_cnt <= r_calib_cnt + CAL_W'(1);
            if (r_calib_cnt == CAL_W'(CALIB_CYCLES - 1))
                r_calib <= 1'b1;
        end
    end

    logic w_thr_ok;
`ifdef DRAM_RDY_THROTTLE_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_x)
            r_lfsr <= 16'hACE1;
        else
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign w_thr_ok = (r_lfsr[1:0] != 2'b00);
`else
    assign w_thr_ok = 1'b1;
`endif

    // ---------------- command / write-data FIFOs ----------------
    logic [APP_CMD_WIDTH-1:0]  r_cmd_q_cmd [FIFO_DEPTH];
    logic [MEM_LINES_LOG2-1:0] r_cmd_q_idx [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_cmd_wr_ptr;
    logic [PTR_W-1:0]          r_cmd_rd_ptr;
    logic [CNT_W-1:0]          r_cmd_cnt;

    logic [APP_DATA_WIDTH-1:0] r_wdf_q_data [FIFO_DEPTH];
    logic [APP_MASK_WIDTH-1:0] r_wdf_q_mask [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wdf_wr_ptr;
    logic [PTR_W-1:0]          r_wdf_rd_ptr;
    logic [CNT_W-1:0]          r_wdf_cnt;

    logic w_cmd_full, w_wdf_full, w_cmd_push, w_wdf_push;
    logic w_cmd_pop, w_wdf_pop;

    assign w_cmd_full    = (r_cmd_cnt == CNT_W'(FIFO_DEPTH));
    assign w_wdf_full    = (r_wdf_cnt == CNT_W'(FIFO_DEPTH));
    assign o_app_rdy     = r_calib & ~w_cmd_full & w_thr_ok;
    assign o_app_wdf_rdy = r_calib & ~w_wdf_full & w_thr_ok;
    assign w_cmd_push    = i_app_en & o_app_rdy;
    assign w_wdf_push    = i_app_wdf_wren & o_app_wdf_rdy;

    always_ff @(posedge i_clk) begin
        if (w_cmd_push) begin
            r_cmd_q_cmd[r_cmd_wr_ptr] <= i_app_cmd;
            r_cmd_q_idx[r_cmd_wr_ptr] <= i_app_addr[MEM_LINES_LOG2+2:3];
        end
        if (w_wdf_push) begin
            r_wdf_q_data[r_wdf_wr_ptr] <= i_app_wdf_data;
            r_wdf_q_mask[r_wdf_wr_ptr] <= i_app_wdf_mask;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_x) begin
            r_cmd_wr_ptr <= '0;
            r_cmd_rd_ptr <= '0;
            r_cmd_cnt    <= '0;
            r_wdf_wr_ptr <= '0;
            r_wdf_rd_ptr <= '0;
            r_wdf_cnt    <= '0;
        end else begin
            if (w_cmd_push) r_cmd_wr_ptr <= r_cmd_wr_ptr + PTR_W'(1);
            if (w_cmd_pop)  r_cmd_rd_ptr <= r_cmd_rd_ptr + PTR_W'(1);
            if (w_wdf_push) r_wdf_wr_ptr <= r_wdf_wr_ptr + PTR_W'(1);
            if (w_wdf_pop)  r_wdf_rd_ptr <= r_wdf_rd_ptr + PTR_W'(1);
            r_cmd_cnt <= r_cmd_cnt + CNT_W'(w_cmd_push) - CNT_W'(w_cmd_pop);
            r_wdf_cnt <= r_wdf_cnt + CNT_W'(w_wdf_push) - CNT_W'(w_wdf_pop);
        end
    end

    // ---------------- execute stage ----------------
    logic [APP_CMD_WIDTH-1:0]  w_head_cmd;
    logic [MEM_LINES_LOG2-1:0] w_head_idx;
    logic [APP_DATA_WIDTH-1:0] w_head_data;
    logic [APP_MASK_WIDTH-1:0] w_head_mask;
    logic                      w_cmd_avail, w_wdf_avail;
    logic                      w_wr_retire, w_rd_retire;

    assign w_head_cmd  = r_cmd_q_cmd[r_cmd_rd_ptr];
    assign w_head_idx  = r_cmd_q_idx[r_cmd_rd_ptr];
    assign w_head_data = r_wdf_q_data[r_wdf_rd_ptr];
    assign w_head_mask = r_wdf_q_mask[r_wdf_rd_ptr];
    assign w_cmd_avail = (r_cmd_cnt != '0);
    assign w_wdf_avail = (r_wdf_cnt != '0);

    // A write without its data stalls the whole queue; everything else retires at once.
    assign w_cmd_pop   = w_cmd_avail & ((w_head_cmd != CMD_WRITE) | w_wdf_avail);
    assign w_wr_retire = w_cmd_pop & (w_head_cmd == CMD_WRITE);
    assign w_rd_retire = w_cmd_pop & (w_head_cmd == CMD_READ);
    assign w_wdf_pop   = w_wr_retire;

    logic [APP_DATA_WIDTH-1:0] r_mem [MEM_LINES];
    logic [APP_DATA_WIDTH-1:0] w_mem_rd;

    assign w_mem_rd = r_mem[w_head_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst_x && w_wr_retire) begin
            for (int b = 0; b < APP_MASK_WIDTH; b++) begin
                if (!w_head_mask[b])
                    r_mem[w_head_idx][b*8 +: 8] <= w_head_data[b*8 +: 8];
            end
        end
    end

    // ---------------- read pipeline: stage 0 at retire, stage RD_LATENCY drives the port ----------------
    logic [APP_DATA_WIDTH-1:0] r_rd_data_p [RD_LATENCY+1];
    logic                      r_rd_vld_p  [RD_LATENCY+1];

    always_ff @(posedge i_clk) begin
        r_rd_data_p[0] <= w_mem_rd;
        for (int s = 1; s < RD_LATENCY; s++)
            r_rd_data_p[s] <= r_rd_data_p[s-1];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_x) begin
            for (int s = 0; s <= RD_LATENCY; s++)
                r_rd_vld_p[s] <= 1'b0;
            r_rd_data_p[RD_LATENCY] <= '0;
        end else begin
            r_rd_vld_p[0] <= w_rd_retire;
            for (int s = 1; s <= RD_LATENCY; s++)
                r_rd_vld_p[s] <= r_rd_vld_p[s-1];
            if (r_rd_vld_p[RD_LATENCY-1])
                r_rd_data_p[RD_LATENCY] <= r_rd_data_p[RD_LATENCY-1];
        end
    end

    assign o_app_rd_data         = r_rd_data_p[RD_LATENCY];
    assign o_app_rd_data_valid   = r_rd_vld_p[RD_LATENCY];
    assign o_app_rd_data_end     = r_rd_vld_p[RD_LATENCY];
    assign o_init_calib_complete = r_calib;

    // Address bits outside the line index and the end strobe carry no information here.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, i_app_wdf_end, i_app_addr};

endmodule

// File: tb/tb_m_dram_app_responder.sv
// Directed bench for m_dram_app_responder: calibration, write/read, masking, late data,
// backpressure, index aliasing and reset during an outstanding read.
module tb_m_dram_app_responder;

    logic         clk;
    logic         rst_x;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] wdf_data;
    logic [15:0]  wdf_mask;
    logic         wdf_wren;
    logic         wdf_end;
    logic         wdf_rdy;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         rd_end;
    logic         calib;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [127:0] D4 = 128'h55AA55AA_11112222_33334444_66667777;
    localparam logic [127:0] DM = 128'hFFFFFFFFFFFFFFFF_0000000000000000;

    m_dram_app_responder dut (
        .i_clk                 (clk),
        .i_rst_x               (rst_x),
        .i_app_addr            (app_addr),
        .i_app_cmd             (app_cmd),
        .i_app_en              (app_en),
        .o_app_rdy             (app_rdy),
        .i_app_wdf_data        (wdf_data),
        .i_app_wdf_mask        (wdf_mask),
        .i_app_wdf_wren        (wdf_wren),
        .i_app_wdf_end         (wdf_end),
        .o_app_wdf_rdy         (wdf_rdy),
        .o_app_rd_data         (rd_data),
        .o_app_rd_data_valid   (rd_valid),
        .o_app_rd_data_end     (rd_end),
        .o_init_calib_complete (calib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
        app_en   = 1'b1; app_cmd = 3'b000; app_addr = a;
        wdf_wren = 1'b1; wdf_end = 1'b1; wdf_data = d; wdf_mask = m;
        tick();
        app_en = 1'b0; wdf_wren = 1'b0; wdf_end = 1'b0;
    endtask

    // Ticks until valid is seen (at least one tick), checks the cycle count and the beat.
    task automatic wait_rd(input string tag, input logic [127:0] exp, input int exp_lat);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!rd_valid && k < 40);
        chk({tag, "_lat"}, 128'(k), 128'(exp_lat));
        chk({tag, "_data"}, rd_data, exp);
        chk({tag, "_end"}, {127'b0, rd_end}, 128'd1);
    endtask

    task automatic do_read(input string tag, input logic [27:0] a, input logic [127:0] exp);
        app_en = 1'b1; app_cmd = 3'b001; app_addr = a;
        tick();
        app_en = 1'b0;
        wait_rd(tag, exp, 9);
        tick();
        chk({tag, "_single"}, {127'b0, rd_valid}, 128'd0);
    endtask

    initial begin
        int vcount;
        rst_x = 1'b0; app_addr = '0; app_cmd = '0; app_en = 1'b0;
        wdf_data = '0; wdf_mask = '0; wdf_wren = 1'b0; wdf_end = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_rdy",    {127'b0, app_rdy},  128'd0);
        chk("rst_wdfrdy", {127'b0, wdf_rdy},  128'd0);
        chk("rst_valid",  {127'b0, rd_valid}, 128'd0);
        chk("rst_end",    {127'b0, rd_end},   128'd0);
        chk("rst_calib",  {127'b0, calib},    128'd0);
        chk("rst_data",   rd_data,            128'd0);

        // Calibration completes after exactly 16 edges from release
        rst_x = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) begin
                chk("cal15_calib",  {127'b0, calib},   128'd0);
                chk("cal15_rdy",    {127'b0, app_rdy}, 128'd0);
                chk("cal15_wdfrdy", {127'b0, wdf_rdy}, 128'd0);
            end
        end
        chk("cal16_calib",  {127'b0, calib},   128'd1);
        chk("cal16_rdy",    {127'b0, app_rdy}, 128'd1);
        chk("cal16_wdfrdy", {127'b0, wdf_rdy}, 128'd1);

        // Write then read
        wr(28'h10, D1, 16'h0000);
        do_read("wr_rd", 28'h10, D1);

        // Index aliasing: low 3 bits and bits above the index are ignored
        do_read("alias_lo", 28'h17, D1);
        do_read("alias_wrap", 28'h2010, D1);

        // Masked write
        wr(28'h30, {128{1'b1}}, 16'h0000);
        wr(28'h30, 128'h0, 16'hFF00);
        do_read("masked", 28'h30, DM);

        // Write data arrives late; the following read waits behind it
        app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'h20;
        tick();
        app_cmd = 3'b001;
        tick();
        app_en = 1'b0;
        vcount = 0;
        repeat (4) begin
            tick();
            if (rd_valid) vcount++;
        end
        chk("late_novalid", 128'(vcount), 128'd0);
        wdf_wren = 1'b1; wdf_end = 1'b1; wdf_data = D2; wdf_mask = 16'h0000;
        tick();
        wdf_wren = 1'b0; wdf_end = 1'b0;
        wait_rd("late", D2, 10);

        // Backpressure: blocked write plus three reads fill the queue
        repeat (3) tick();
        app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'h40;
        tick();
        app_cmd = 3'b001; app_addr = 28'h10; tick();
        app_addr = 28'h30; tick();
        app_addr = 28'h20; tick();
        chk("bp_full_rdy", {127'b0, app_rdy}, 128'd0);
        app_addr = 28'h40;
        wdf_wren = 1'b1; wdf_end = 1'b1; wdf_data = D4; wdf_mask = 16'h0000;
        tick();
        wdf_wren = 1'b0; wdf_end = 1'b0;
        chk("bp_still_full", {127'b0, app_rdy}, 128'd0);
        tick();
        chk("bp_reassert", {127'b0, app_rdy}, 128'd1);
        tick();
        app_en = 1'b0;
        wait_rd("bp_r0", D1, 8);
        wait_rd("bp_r1", DM, 1);
        wait_rd("bp_r2", D2, 1);
        wait_rd("bp_r3", D4, 1);
        tick();
        chk("bp_done", {127'b0, rd_valid}, 128'd0);

        // Reset during an outstanding read
        repeat (3) tick();
        app_en = 1'b1; app_cmd = 3'b001; app_addr = 28'h10;
        tick();
        app_en = 1'b0;
        tick();
        tick();
        rst_x = 1'b0;
        tick();
        rst_x = 1'b1;
        chk("mid_rst_calib", {127'b0, calib}, 128'd0);
        vcount = 0;
        repeat (16) begin
            if (rd_valid) vcount++;
            tick();
        end
        if (rd_valid) vcount++;
        chk("mid_rst_novalid", 128'(vcount), 128'd0);
        chk("mid_rst_recal", {127'b0, calib}, 128'd1);
        do_read("after_rst", 28'h10, D1);
        do_read("after_rst_m", 28'h30, DM);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
